// File: rtl/car_warning_if.sv
// Cabin-switch / chime-driver bundle for car_warning_ctrl.
// master drives the raw switches and Ack; slave is the controller.
interface car_warning_if;
  logic       door_close;
  logic       ignition;
  logic       seat_belt;
  logic       ack;
  logic       alarm;
  logic       warn_lamp;
  logic [1:0] cause;
  logic [2:0] state;

  modport master (output door_close, ignition, seat_belt, ack,
                  input  alarm, warn_lamp, cause, state);
  modport slave  (input  door_close, ignition, seat_belt, ack,
                  output alarm, warn_lamp, cause, state);
endinterface

// File: rtl/car_warning_ctrl.sv
// Debounced driver-warning sequencer: grace -> pulsed chime -> steady,
// with driver mute that re-arms when a new cause appears.
module car_warning_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int GRACE_CYC    = 16,
  parameter int CHIME_ON     = 4,
  parameter int CHIME_OFF    = 4,
  parameter int CHIME_MAX    = 8
) (
  input logic         clk,
  input logic         rst_n,
  car_warning_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GRACE  = 3'd1;
  localparam logic [2:0] CHIME  = 3'd2;
  localparam logic [2:0] STEADY = 3'd3;
  localparam logic [2:0] MUTED  = 3'd4;

  localparam int PER = CHIME_ON + CHIME_OFF;
  localparam int DW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int GW  = $clog2(GRACE_CYC + 1);
  localparam int PW  = $clog2(PER + 1);
  localparam int MW  = $clog2(CHIME_MAX + 1);

  // bit order {belt, ignition, door}; reset values give no fault
  localparam logic [2:0] ACC_RST = 3'b101;

  logic [2:0] raw, acc;
  assign raw = {bus.seat_belt, bus.ignition, bus.door_close};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic          a;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a   <= ACC_RST[i];
        cnt <= '0;
      end else if (raw[i] == a) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
        a   <= raw[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
    assign acc[i] = a;
  end

  logic       door_f, belt_f, fault;
  logic [1:0] cur;
  assign door_f = acc[1] & ~acc[0];
  assign belt_f = acc[1] & ~acc[2];
  assign cur    = {door_f, belt_f};
  assign fault  = door_f | belt_f;

  logic [2:0]    state, nxt;
  logic [GW-1:0] gtmr, nxt_g;
  logic [PW-1:0] ph, nxt_ph;
  logic [MW-1:0] per, nxt_per;
  logic [1:0]    latch, nxt_latch;
  logic          alarm, lamp, nxt_alarm, nxt_lamp;
  logic [1:0]    cause;

  always_comb begin
    nxt       = state;
    nxt_g     = gtmr;
    nxt_ph    = ph;
    nxt_per   = per;
    nxt_latch = latch;
    case (state)
      IDLE: begin
        if (door_f)      nxt = CHIME;
        else if (belt_f) nxt = GRACE;
      end
      GRACE: begin
        if (!fault)                            nxt = IDLE;
        else if (door_f)                       nxt = CHIME;
        else if (gtmr == GW'(GRACE_CYC - 1))   nxt = CHIME;
        else                                   nxt_g = gtmr + GW'(1);
      end
      CHIME: begin
        if (!fault) nxt = IDLE;
        else if (bus.ack) begin
          nxt       = MUTED;
          nxt_latch = cur;
        end else if (ph == PW'(PER - 1)) begin
          nxt_ph = '0;
          if (per == MW'(CHIME_MAX - 1)) nxt = STEADY;
          else                           nxt_per = per + MW'(1);
        end else begin
          nxt_ph = ph + PW'(1);
        end
      end
      STEADY: begin
        if (!fault) nxt = IDLE;
        else if (bus.ack) begin
          nxt       = MUTED;
          nxt_latch = cur;
        end
      end
      MUTED: begin
        if (!fault)              nxt = IDLE;
        else if (|(cur & ~latch)) nxt = CHIME;
      end
      default: nxt = IDLE;
    endcase
    // every state entry starts its timers from zero
    if (nxt != state) begin
      nxt_g   = '0;
      nxt_ph  = '0;
      nxt_per = '0;
    end
    nxt_alarm = ((nxt == CHIME) && (nxt_ph < PW'(CHIME_ON))) || (nxt == STEADY);
    nxt_lamp  = (nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gtmr  <= '0;
      ph    <= '0;
      per   <= '0;
      latch <= '0;
      alarm <= 1'b0;
      lamp  <= 1'b0;
      cause <= '0;
    end else begin
      state <= nxt;
      gtmr  <= nxt_g;
      ph    <= nxt_ph;
      per   <= nxt_per;
      latch <= nxt_latch;
      alarm <= nxt_alarm;
      lamp  <= nxt_lamp;
      cause <= cur;
    end
  end

  assign bus.state     = state;
  assign bus.alarm     = alarm;
  assign bus.warn_lamp = lamp;
  assign bus.cause     = cause;
endmodule

// File: doc/car_warning_ctrl.md
# car_warning_ctrl

Sequenced driver-warning controller for the car alarm path. It debounces the door, ignition and seat-belt inputs, then runs a grace / chime / steady / muted state machine. Its outputs are a pulsed or steady chime (Alarm), a warning lamp and a cause code. It sits between the raw cabin switches and the chime driver, and replaces the purely combinational alarm decode with timed, acknowledgeable behaviour.

## Interface
- DEBOUNCE_CYC, 4, consecutive stable cycles required before a raw input is accepted (>=1)
- GRACE_CYC, 16, cycles of lamp-only warning for an unbuckled belt before chiming (>=1)
- CHIME_ON, 4, cycles Alarm is high per chime period (>=1)
- CHIME_OFF, 4, cycles Alarm is low per chime period (>=1)
- CHIME_MAX, 8, chime periods before switching to steady alarm (>=1)
- Clk  input  1  system clock, rising-edge
- RstN  input  1  reset, asynchronous, active-low
- DoorClose  input  1  raw door switch, 1 = closed
- Ignition  input  1  raw ignition, 1 = on
- SeatBelt  input  1  raw belt switch, 1 = fastened
- Ack  input  1  driver acknowledge, sampled per cycle, level-sensitive
- Alarm  output  1  chime drive
- WarnLamp  output  1  dashboard warning lamp
- Cause  output  2  {door_open, belt_open}, qualified by Ignition
- State  output  3  FSM state: IDLE=0, GRACE=1, CHIME=2, STEADY=3, MUTED=4

## Operation
- Debounce: each input has its own counter and accepted value. The counter resets whenever raw equals accepted. The accepted value flips in the cycle its counter reaches DEBOUNCE_CYC, i.e. raw must differ for DEBOUNCE_CYC consecutive samples.
- Reset values of accepted inputs: DoorClose=1, SeatBelt=1, Ignition=0, so there is no fault out of reset.
- door_f = Ignition_a & ~DoorClose_a
- belt_f = Ignition_a & ~SeatBelt_a
- fault = door_f | belt_f
- Cause = {door_f, belt_f}, registered.
- IDLE: Alarm=0, WarnLamp=0.
  - door_f -> CHIME (no grace).
  - else belt_f -> GRACE.
- GRACE: Alarm=0, WarnLamp=1.
  - ~fault -> IDLE.
  - door_f -> CHIME.
  - After GRACE_CYC cycles in GRACE -> CHIME.
- CHIME: WarnLamp=1. Alarm is high for CHIME_ON cycles, then low for CHIME_OFF cycles, starting high on entry.
  - After CHIME_MAX complete periods -> STEADY.
  - ~fault -> IDLE.
  - Ack -> MUTED.
- STEADY: Alarm=1, WarnLamp=1.
  - ~fault -> IDLE.
  - Ack -> MUTED.
- MUTED: Alarm=0, WarnLamp=1. The cause present at entry is latched.
  - ~fault -> IDLE.
  - A cause bit that rises and is not in the latched cause -> CHIME, with the period counter and pulse counter cleared.
- Priority in every state: ~fault > new/door cause > Ack > timer expiry.
- Ack outside CHIME/STEADY is ignored. Holding Ack through a CHIME re-entry from MUTED re-mutes it next cycle.
- Counter widths: $clog2(param+1). Timers clear on every state entry and never wrap.

## Timing
- All outputs are registered and reflect the state register directly. There is no combinational input-to-output path.
- Reset (RstN low): immediately, asynchronously:
  - State=IDLE
  - Alarm=0, WarnLamp=0, Cause=0
  - all counters 0
- Input-to-state latency: raw change at cycle 0 gives the accepted value at cycle DEBOUNCE_CYC and the new State/outputs at cycle DEBOUNCE_CYC+1.
- GRACE occupies exactly GRACE_CYC cycles.
- CHIME occupies exactly CHIME_MAX*(CHIME_ON+CHIME_OFF) cycles, then STEADY.
- Ack sampled at cycle n in CHIME/STEADY gives State=MUTED and Alarm=0 at cycle n+1.
- Ack and fault clearing in the same cycle: result is IDLE.
- Door and belt faults arriving in the same cycle from IDLE: result is CHIME with Cause=2'b11.
- RstN asserted mid-CHIME: Alarm drops to 0 without waiting for Clk. After release, the FSM resumes from IDLE and must re-debounce before any warning.

## Test plan
- **Reset:** assert RstN=0 with Ignition=1 and SeatBelt=0 raw -> Alarm=0, WarnLamp=0, Cause=0, State=0 during reset and for DEBOUNCE_CYC+1 cycles after release.
- **Belt grace:** Ignition=1, DoorClose=1, SeatBelt 1->0 at cycle 0, then fastened again at cycle 10 -> WarnLamp=1 from cycle 5, State returns to IDLE by cycle 15, Alarm never 1.
- **Full sequence:** belt held open -> first Alarm high at cycle 21, then 8 periods of 4 high / 4 low, then State=STEADY with Alarm=1 from cycle 85.
- **Door open:** DoorClose 1->0 with Ignition=1 -> State=CHIME at cycle 5 with Alarm=1, Cause=2'b10, no GRACE.
- **Mute and re-arm:** Ack in CHIME with belt cause -> MUTED next cycle, Alarm=0, WarnLamp=1. Then open the door -> CHIME 5 cycles after the raw edge, Cause=2'b11.
- **Glitch and async reset:** SeatBelt low for 3 cycles -> no state change. RstN low mid-CHIME -> Alarm=0 before the next Clk edge.
